breadboard_sweep_checker: RTL

//   Sequential driver and checker for the 4-in/10-out combinational breadboard.

---
 rtl/breadboard_sweep_checker_if.sv | 20 ++
 rtl/breadboard_sweep_checker.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/breadboard_sweep_checker_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Interface   : breadboard_sweep_checker_if
//  Description : Per-row result stream (valid/ready) from the sweep checker
//                to the lab result logger.
//                data = {mismatch, idx[3:0], sampled resp[9:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
interface breadboard_sweep_checker_if;
  logic        valid;
  logic        ready;
  logic [14:0] data;

  // Producer side: the sweep checker
  modport master (output valid, output data, input ready);
  // Consumer side: the result logger
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/breadboard_sweep_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : breadboard_sweep_checker
//  Description : Drives all 16 input codes into a 4-in/10-out breadboard,
//                samples each response after SETTLE cycles, compares it with
//                the GOLDEN table, streams one result beat per row and keeps
//                a pass/fail summary of the sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module breadboard_sweep_checker #(
  parameter int           SETTLE = 2,       // 1..255 drive cycles per row
  parameter logic [159:0] GOLDEN = 160'h0   // row i at GOLDEN[10*i+9 : 10*i]
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        i_start,
  output      logic [3:0]                  o_dut_in,
  input  wire logic [9:0]                  i_dut_resp,
  output      logic                        o_busy,
  output      logic                        o_done,
  output      logic                        o_pass,
  output      logic [4:0]                  o_err_count,
  output      logic [3:0]                  o_first_fail,
  output      logic                        o_first_fail_vld,
  breadboard_sweep_checker_if.master       res
);

  // Reload value of the settle down-counter; the counter reaching zero marks
  // the last drive cycle, so DRIVE lasts exactly SETTLE cycles.
  localparam logic [7:0] c_SETTLE_RELOAD = 8'(SETTLE - 1);
  localparam logic [3:0] c_LAST_ROW      = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_cnt;
  logic [3:0]  r_idx;
  logic [14:0] r_data;
  logic [4:0]  r_err;
  logic [3:0]  r_first_fail;
  logic        r_first_fail_vld;
  logic        r_pass;

  logic [9:0]  w_gold_row;
  logic        w_mismatch;
  logic        w_settled;
  logic        w_handshake;

  // Select the golden row for the code currently applied to the breadboard
  always_comb begin
    w_gold_row = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_idx == 4'(i)) begin
        w_gold_row = GOLDEN[10*i +: 10];
      end
    end
  end

  assign w_mismatch  = (i_dut_resp != w_gold_row);
  assign w_settled   = (r_cnt == 8'd0);
  assign w_handshake = (r_state == ST_EMIT) && res.ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start)   w_next = ST_DRIVE;
      ST_DRIVE: if (w_settled) w_next = ST_EMIT;
      ST_EMIT: begin
        if (res.ready) begin
          w_next = (r_idx == c_LAST_ROW) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Sweep datapath: row index, settle timer, sampled beat and summary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt            <= '0;
      r_idx            <= '0;
      r_data           <= '0;
      r_err            <= '0;
      r_first_fail     <= '0;
      r_first_fail_vld <= 1'b0;
      r_pass           <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_idx            <= '0;
            r_cnt            <= c_SETTLE_RELOAD;
            r_err            <= '0;
            r_first_fail_vld <= 1'b0;
            r_pass           <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (w_settled) begin
            // Only this edge looks at the breadboard response
            r_data <= {w_mismatch, r_idx, i_dut_resp};
            if (w_mismatch) begin
              r_err <= r_err + 5'd1;
              if (!r_first_fail_vld) begin
                r_first_fail     <= r_idx;
                r_first_fail_vld <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_EMIT: begin
          if (w_handshake) begin
            if (r_idx == c_LAST_ROW) begin
              // err_count is final here, so pass is valid alongside done
              r_pass <= (r_err == 5'd0);
            end else begin
              r_idx <= r_idx + 4'd1;
              r_cnt <= c_SETTLE_RELOAD;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_dut_in         = r_idx;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_done           = (r_state == ST_DONE);
  assign o_pass           = r_pass;
  assign o_err_count      = r_err;
  assign o_first_fail     = r_first_fail;
  assign o_first_fail_vld = r_first_fail_vld;
  assign res.valid        = (r_state == ST_EMIT);
  assign res.data         = r_data;

endmodule
`default_nettype wire
